// File: rtl/ibex_mem_port_arbiter_if.sv
// Bus bundle between the two SRAM-side requesters,
// the shared memory port and the arbiter.
interface ibex_mem_port_arbiter_if #(
  parameter int Aw = 18,
  parameter int Dw = 32
) ();
  logic          instr_req_i;
  logic          instr_gnt_o;
  logic          instr_we_i;
  logic [Aw-1:0] instr_addr_i;
  logic [Dw-1:0] instr_wdata_i;
  logic [Dw-1:0] instr_strb_i;
  logic [Dw-1:0] instr_rdata_o;
  logic          instr_rvalid_o;

  logic          data_req_i;
  logic          data_gnt_o;
  logic          data_we_i;
  logic [Aw-1:0] data_addr_i;
  logic [Dw-1:0] data_wdata_i;
  logic [Dw-1:0] data_strb_i;
  logic [Dw-1:0] data_rdata_o;
  logic          data_rvalid_o;

  logic          mem_req_o;
  logic          mem_gnt_i;
  logic          mem_we_o;
  logic [Aw-1:0] mem_addr_o;
  logic [Dw-1:0] mem_wdata_o;
  logic [Dw-1:0] mem_strb_o;
  logic [Dw-1:0] mem_rdata_i;

  // Arbiter side
  modport slave (
    input  instr_req_i, instr_we_i, instr_addr_i,
    input  instr_wdata_i, instr_strb_i,
    output instr_gnt_o, instr_rdata_o, instr_rvalid_o,
    input  data_req_i, data_we_i, data_addr_i,
    input  data_wdata_i, data_strb_i,
    output data_gnt_o, data_rdata_o, data_rvalid_o,
    output mem_req_o, mem_we_o, mem_addr_o,
    output mem_wdata_o, mem_strb_o,
    input  mem_gnt_i, mem_rdata_i
  );

  // Requester/memory side
  modport master (
    output instr_req_i, instr_we_i, instr_addr_i,
    output instr_wdata_i, instr_strb_i,
    input  instr_gnt_o, instr_rdata_o, instr_rvalid_o,
    output data_req_i, data_we_i, data_addr_i,
    output data_wdata_i, data_strb_i,
    input  data_gnt_o, data_rdata_o, data_rvalid_o,
    input  mem_req_o, mem_we_o, mem_addr_o,
    input  mem_wdata_o, mem_strb_o,
    output mem_gnt_i, mem_rdata_i
  );
endinterface

// File: rtl/ibex_mem_port_arbiter.sv
// Shares one 1-cycle SRAM between instr and data requesters.
// Optional perf counters: define MEM_ARB_PERF_CNT_EN.
module ibex_mem_port_arbiter #(
  parameter int Aw      = 18,
  parameter int Dw      = 32,
  parameter int ArbMode = 0,
  parameter int MaxWait = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  ibex_mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] conflict_cnt_o,
  output logic [31:0] instr_stall_cnt_o
`endif
);
  localparam int AgeW = $clog2(MaxWait + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(MaxWait);

  typedef enum logic {
    SEL_INSTR = 1'b0,
    SEL_DATA  = 1'b1
  } sel_e;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  lock_e         lock_q, lock_d;
  sel_e          lock_own_q, lock_own_d;
  sel_e          last_q, last_d;
  sel_e          rd_own_q, rd_own_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AgeW-1:0] age_q, age_d;

  sel_e          pol_sel, sel;
  logic          mem_req, accept;
  logic          instr_gnt, data_gnt;
  logic          we_mux;
  logic [Aw-1:0] addr_mux;
  logic [Dw-1:0] wdata_mux, strb_mux;
  logic          instr_rvalid, data_rvalid;

  // Policy choice when no transfer is locked in
  always_comb begin
    pol_sel = last_q;
    unique case ({bus.instr_req_i, bus.data_req_i})
      2'b10: pol_sel = SEL_INSTR;
      2'b01: pol_sel = SEL_DATA;
      2'b11: begin
        if (ArbMode == 0) begin
          pol_sel = (last_q == SEL_DATA) ? SEL_INSTR : SEL_DATA;
        end else begin
          pol_sel = (age_q == AgeMax) ? SEL_INSTR : SEL_DATA;
        end
      end
      default: pol_sel = last_q;
    endcase
  end

  // Owner selection and command mux; gnt never feeds sel
  always_comb begin
    sel     = (lock_q == LOCKED) ? lock_own_q : pol_sel;
    mem_req = bus.instr_req_i | bus.data_req_i;
    accept  = mem_req & bus.mem_gnt_i;
    instr_gnt = accept & (sel == SEL_INSTR);
    data_gnt  = accept & (sel == SEL_DATA);
    if (sel == SEL_INSTR) begin
      we_mux    = bus.instr_we_i;
      addr_mux  = bus.instr_addr_i;
      wdata_mux = bus.instr_wdata_i;
      strb_mux  = bus.instr_strb_i;
    end else begin
      we_mux    = bus.data_we_i;
      addr_mux  = bus.data_addr_i;
      wdata_mux = bus.data_wdata_i;
      strb_mux  = bus.data_strb_i;
    end
  end

  // Lock, fairness, aging and read-return next state
  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    unique case (lock_q)
      UNLOCKED: begin
        if (mem_req && !bus.mem_gnt_i) begin
          lock_d     = LOCKED;
          lock_own_d = sel;
        end
      end
      LOCKED: begin
        if (accept) lock_d = UNLOCKED;
      end
      default: lock_d = UNLOCKED;
    endcase
    last_d = accept ? sel : last_q;
    age_d  = age_q;
    if (instr_gnt) begin
      age_d = '0;
    end else if (bus.instr_req_i && age_q != AgeMax) begin
      age_d = age_q + AgeW'(1);
    end
    rd_pend_d = accept & ~we_mux;
    rd_own_d  = accept ? sel : rd_own_q;
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= UNLOCKED;
      lock_own_q <= SEL_DATA;
      last_q     <= SEL_DATA;
      age_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_own_q   <= SEL_DATA;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      last_q     <= last_d;
      age_q      <= age_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_q   <= rd_own_d;
    end
  end

  // Responses go only to the owner; others see zero data
  always_comb begin
    instr_rvalid = rd_pend_q & (rd_own_q == SEL_INSTR) & ~rst_i;
    data_rvalid  = rd_pend_q & (rd_own_q == SEL_DATA) & ~rst_i;
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = we_mux;
  assign bus.mem_addr_o     = addr_mux;
  assign bus.mem_wdata_o    = wdata_mux;
  assign bus.mem_strb_o     = strb_mux;
  assign bus.instr_gnt_o    = instr_gnt;
  assign bus.data_gnt_o     = data_gnt;
  assign bus.instr_rvalid_o = instr_rvalid;
  assign bus.data_rvalid_o  = data_rvalid;
  assign bus.instr_rdata_o  = instr_rvalid ? bus.mem_rdata_i : '0;
  assign bus.data_rdata_o   = data_rvalid ? bus.mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Conflict and instr-stall counters, wrapping
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (bus.instr_req_i && bus.data_req_i) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if (bus.instr_req_i && !instr_gnt) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign conflict_cnt_o    = conflict_cnt_q;
  assign instr_stall_cnt_o = stall_cnt_q;
`endif

  // A locked owner must keep requesting until accepted
  a_hold_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (lock_q == LOCKED) |->
      ((lock_own_q == SEL_INSTR) ? bus.instr_req_i
                                 : bus.data_req_i)
  );
endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Directed bench for ibex_mem_port_arbiter:
// round-robin instance (a) and data-priority instance (b).
module tb_ibex_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ibex_mem_port_arbiter_if #(.Aw(18), .Dw(32)) bus_a ();
  ibex_mem_port_arbiter_if #(.Aw(18), .Dw(32)) bus_b ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] cc_a, sc_a, cc_b, sc_b;
`endif

  ibex_mem_port_arbiter #(
    .Aw(18), .Dw(32), .ArbMode(0), .MaxWait(8)
  ) u_dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_a)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o   (cc_a),
    .instr_stall_cnt_o(sc_a)
`endif
  );

  ibex_mem_port_arbiter #(
    .Aw(18), .Dw(32), .ArbMode(1), .MaxWait(4)
  ) u_dut_b (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_b)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o   (cc_b),
    .instr_stall_cnt_o(sc_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_a();
    bus_a.instr_req_i = 0; bus_a.instr_we_i = 0;
    bus_a.instr_addr_i = '0; bus_a.instr_wdata_i = '0;
    bus_a.instr_strb_i = '0;
    bus_a.data_req_i = 0; bus_a.data_we_i = 0;
    bus_a.data_addr_i = '0; bus_a.data_wdata_i = '0;
    bus_a.data_strb_i = '0;
    bus_a.mem_gnt_i = 0; bus_a.mem_rdata_i = '0;
  endtask

  task automatic clr_b();
    bus_b.instr_req_i = 0; bus_b.instr_we_i = 0;
    bus_b.instr_addr_i = '0; bus_b.instr_wdata_i = '0;
    bus_b.instr_strb_i = '0;
    bus_b.data_req_i = 0; bus_b.data_we_i = 0;
    bus_b.data_addr_i = '0; bus_b.data_wdata_i = '0;
    bus_b.data_strb_i = '0;
    bus_b.mem_gnt_i = 0; bus_b.mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    clr_a(); clr_b();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clr_a(); clr_b();
    rst = 1;
    tick(); tick();
    #1;
    total++;
    if (bus_a.instr_rvalid_o !== 1'b0 || bus_a.data_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_rvalid got i=%b d=%b want 0 0",
               bus_a.instr_rvalid_o, bus_a.data_rvalid_o);
    end
    total++;
    if (bus_a.instr_rdata_o !== 32'h0 || bus_a.data_rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata got i=%h d=%h want 0",
               bus_a.instr_rdata_o, bus_a.data_rdata_o);
    end
    total++;
    if (bus_a.mem_req_o !== 1'b0 || bus_a.instr_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_req got req=%b gnt=%b want 0 0",
               bus_a.mem_req_o, bus_a.instr_gnt_o);
    end
`ifdef MEM_ARB_PERF_CNT_EN
    total++;
    if (cc_a !== 32'd0 || sc_a !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt got %0d %0d want 0 0", cc_a, sc_a);
    end
`endif
    rst = 0;
  endtask

  task automatic test_solo_read();
    bus_a.instr_req_i = 1; bus_a.instr_addr_i = 18'h10;
    bus_a.mem_gnt_i = 1;
    #1;
    total++;
    if (bus_a.instr_gnt_o !== 1'b1 || bus_a.data_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL solo_gnt got i=%b d=%b want 1 0",
               bus_a.instr_gnt_o, bus_a.data_gnt_o);
    end
    total++;
    if (bus_a.mem_addr_o !== 18'h10 || bus_a.mem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL solo_cmd got addr=%h req=%b want 10 1",
               bus_a.mem_addr_o, bus_a.mem_req_o);
    end
    tick();
    bus_a.instr_req_i = 0;
    bus_a.mem_rdata_i = 32'hDEADBEEF;
    #1;
    total++;
    if (bus_a.instr_rvalid_o !== 1'b1 ||
        bus_a.instr_rdata_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL solo_rsp got v=%b d=%h want 1 deadbeef",
               bus_a.instr_rvalid_o, bus_a.instr_rdata_o);
    end
    total++;
    if (bus_a.data_rvalid_o !== 1'b0 || bus_a.data_rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL solo_leak got v=%b d=%h want 0 0",
               bus_a.data_rvalid_o, bus_a.data_rdata_o);
    end
    tick();
    #1;
    total++;
    if (bus_a.instr_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL solo_once got %b want 0", bus_a.instr_rvalid_o);
    end
    clr_a();
  endtask

  task automatic test_round_robin();
    logic        exp_i, prev_i;
    logic [31:0] rd;
    do_reset();
    bus_a.instr_req_i = 1; bus_a.instr_addr_i = 18'h100;
    bus_a.data_req_i = 1;  bus_a.data_addr_i = 18'h200;
    bus_a.mem_gnt_i = 1;
    for (int k = 0; k < 10; k++) begin
      rd = 32'h1000 + 32'(k);
      bus_a.mem_rdata_i = rd;
      #1;
      exp_i = (k % 2 == 0);
      total++;
      if (bus_a.instr_gnt_o !== exp_i || bus_a.data_gnt_o !== !exp_i) begin
        bad++;
        $display("FAIL rr_gnt k=%0d got i=%b d=%b want i=%b",
                 k, bus_a.instr_gnt_o, bus_a.data_gnt_o, exp_i);
      end
      total++;
      if (bus_a.mem_addr_o !== (exp_i ? 18'h100 : 18'h200)) begin
        bad++;
        $display("FAIL rr_addr k=%0d got %h want i=%b",
                 k, bus_a.mem_addr_o, exp_i);
      end
      if (k > 0) begin
        prev_i = ((k - 1) % 2 == 0);
        total++;
        if (bus_a.instr_rvalid_o !== prev_i ||
            bus_a.data_rvalid_o !== !prev_i ||
            bus_a.instr_rdata_o !== (prev_i ? rd : 32'h0) ||
            bus_a.data_rdata_o !== (prev_i ? 32'h0 : rd)) begin
          bad++;
          $display("FAIL rr_rsp k=%0d got iv=%b dv=%b id=%h dd=%h want iv=%b",
                   k, bus_a.instr_rvalid_o, bus_a.data_rvalid_o,
                   bus_a.instr_rdata_o, bus_a.data_rdata_o, prev_i);
        end
      end
      tick();
    end
    bus_a.instr_req_i = 0; bus_a.data_req_i = 0;
    bus_a.mem_rdata_i = 32'h2000;
    #1;
    total++;
    if (bus_a.data_rvalid_o !== 1'b1 || bus_a.data_rdata_o !== 32'h2000 ||
        bus_a.instr_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL rr_last got dv=%b dd=%h iv=%b want 1 2000 0",
               bus_a.data_rvalid_o, bus_a.data_rdata_o,
               bus_a.instr_rvalid_o);
    end
`ifdef MEM_ARB_PERF_CNT_EN
    total++;
    if (cc_a !== 32'd10 || sc_a !== 32'd5) begin
      bad++;
      $display("FAIL perf_cnt got conflict=%0d stall=%0d want 10 5",
               cc_a, sc_a);
    end
`endif
    tick();
    clr_a();
  endtask

  task automatic test_lock();
    tick();
    bus_a.data_req_i = 1; bus_a.data_we_i = 1;
    bus_a.data_addr_i = 18'h3A; bus_a.data_wdata_i = 32'h55AA;
    bus_a.data_strb_i = '1;
    bus_a.mem_gnt_i = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus_a.instr_req_i = 1; bus_a.instr_addr_i = 18'h55;
      end
      if (c == 3) bus_a.mem_gnt_i = 1;
      if (c == 4) bus_a.data_req_i = 0;
      #1;
      total++;
      if (bus_a.data_gnt_o !== (c == 3) || bus_a.instr_gnt_o !== (c == 4)) begin
        bad++;
        $display("FAIL lock_gnt c=%0d got i=%b d=%b",
                 c, bus_a.instr_gnt_o, bus_a.data_gnt_o);
      end
      total++;
      if (bus_a.mem_addr_o !== (c == 4 ? 18'h55 : 18'h3A)) begin
        bad++;
        $display("FAIL lock_addr c=%0d got %h", c, bus_a.mem_addr_o);
      end
      if (c == 4) begin
        total++;
        if (bus_a.data_rvalid_o !== 1'b0 || bus_a.instr_rvalid_o !== 1'b0) begin
          bad++;
          $display("FAIL lock_wr_rsp got dv=%b iv=%b want 0 0",
                   bus_a.data_rvalid_o, bus_a.instr_rvalid_o);
        end
      end
      tick();
    end
    bus_a.instr_req_i = 0;
    bus_a.mem_rdata_i = 32'h77;
    #1;
    total++;
    if (bus_a.instr_rvalid_o !== 1'b1 || bus_a.instr_rdata_o !== 32'h77 ||
        bus_a.data_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL lock_rd_rsp got iv=%b id=%h dv=%b want 1 77 0",
               bus_a.instr_rvalid_o, bus_a.instr_rdata_o,
               bus_a.data_rvalid_o);
    end
    tick();
    clr_a();
  endtask

  task automatic test_priority();
    logic exp_i;
    do_reset();
    bus_b.instr_req_i = 1; bus_b.instr_addr_i = 18'h40;
    bus_b.data_req_i = 1;  bus_b.data_addr_i = 18'h80;
    bus_b.mem_gnt_i = 1;
    for (int w = 1; w <= 6; w++) begin
      #1;
      exp_i = (w == 5);
      total++;
      if (bus_b.instr_gnt_o !== exp_i || bus_b.data_gnt_o !== !exp_i) begin
        bad++;
        $display("FAIL prio_gnt w=%0d got i=%b d=%b want i=%b",
                 w, bus_b.instr_gnt_o, bus_b.data_gnt_o, exp_i);
      end
      if (w == 5) begin
        total++;
        if (u_dut_b.age_q !== 3'd4) begin
          bad++;
          $display("FAIL prio_age_max got %0d want 4", u_dut_b.age_q);
        end
      end
      if (w == 6) begin
        total++;
        if (u_dut_b.age_q !== 3'd0) begin
          bad++;
          $display("FAIL prio_age_clr got %0d want 0", u_dut_b.age_q);
        end
        total++;
        if (bus_b.instr_rvalid_o !== 1'b1 || bus_b.data_rvalid_o !== 1'b0) begin
          bad++;
          $display("FAIL prio_rsp got iv=%b dv=%b want 1 0",
                   bus_b.instr_rvalid_o, bus_b.data_rvalid_o);
        end
      end
      tick();
    end
    clr_b();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    bus_a.instr_req_i = 1; bus_a.instr_addr_i = 18'h20;
    bus_a.mem_gnt_i = 1;
    #1;
    total++;
    if (bus_a.instr_gnt_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_gnt got %b want 1", bus_a.instr_gnt_o);
    end
    tick();
    rst = 1;
    bus_a.instr_req_i = 0;
    bus_a.mem_rdata_i = 32'hCAFEF00D;
    #1;
    total++;
    if (bus_a.instr_rvalid_o !== 1'b0 || bus_a.instr_rdata_o !== 32'h0 ||
        bus_a.data_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_t1 got iv=%b id=%h dv=%b want 0 0 0",
               bus_a.instr_rvalid_o, bus_a.instr_rdata_o,
               bus_a.data_rvalid_o);
    end
    tick();
    rst = 0;
    #1;
    total++;
    if (bus_a.instr_rvalid_o !== 1'b0 || bus_a.data_rvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_t2 got iv=%b dv=%b want 0 0",
               bus_a.instr_rvalid_o, bus_a.data_rvalid_o);
    end
    bus_a.instr_req_i = 1; bus_a.data_req_i = 1;
    bus_a.data_addr_i = 18'h30;
    #1;
    total++;
    if (bus_a.instr_gnt_o !== 1'b1 || bus_a.data_gnt_o !== 1'b0) begin
      bad++;
      $display("FAIL rmid_conflict got i=%b d=%b want 1 0",
               bus_a.instr_gnt_o, bus_a.data_gnt_o);
    end
    tick();
    clr_a();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    clr_a();
    clr_b();
    test_reset();
    test_solo_read();
    test_round_robin();
    test_lock();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
